regfile_onehot_wr: RTL and testbench

//  Register file whose write port consumes the one-hot write-enable vector produced by the

---
 rtl/regfile_onehot_wr.sv | 84 ++++++++
 tb/tb_regfile_onehot_wr.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_onehot_wr.sv
// Register file with a one-hot write-enable port, two registered read ports and a hardwired zero register.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_onehot_wr #(
    parameter int W        = 64,
    parameter int NREG     = 32,
    parameter int ZERO_REG = NREG - 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREG-1:0]         wr_sel,
    input  logic [W-1:0]            wr_data,
    input  logic [$clog2(NREG)-1:0] rd_addr1,
    input  logic [$clog2(NREG)-1:0] rd_addr2,
    output logic [W-1:0]            rd_data1,
    output logic [W-1:0]            rd_data2,
    output logic                    onehot_err
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [W-1:0] regs_q [NREG];
    logic [W-1:0] rd_data1_q, rd_data1_d;
    logic [W-1:0] rd_data2_q, rd_data2_d;
    logic         onehot_err_q;

    logic [AW:0]  wr_cnt;
    logic         wr_valid;
    logic         wr_illegal;
`ifdef REGFILE_BYPASS_EN
    logic [AW-1:0] wr_idx;
`endif

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        wr_cnt = '0;
`ifdef REGFILE_BYPASS_EN
        wr_idx = '0;
`endif
        for (int i = 0; i < NREG; i++) begin
            if (wr_sel[i]) begin
                wr_cnt = wr_cnt + (AW+1)'(1);
`ifdef REGFILE_BYPASS_EN
                wr_idx = wr_idx | AW'(i);
`endif
            end
        end
        wr_valid   = (wr_cnt == (AW+1)'(1));
        wr_illegal = (wr_cnt > (AW+1)'(1));
    end

    always_comb begin
        rd_data1_d = (rd_addr1 == ZERO_IDX) ? '0 : regs_q[rd_addr1];
        rd_data2_d = (rd_addr2 == ZERO_IDX) ? '0 : regs_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        // Forward only a legal write; the zero register is excluded by the address check.
        if (wr_valid && (wr_idx != ZERO_IDX) && (rd_addr1 == wr_idx)) rd_data1_d = wr_data;
        if (wr_valid && (wr_idx != ZERO_IDX) && (rd_addr2 == wr_idx)) rd_data2_d = wr_data;
`endif
    end

    // NOTE: the storage array is reset along with the rest of the state, because the
    // register file must read back zero after reset. This reset is synchronous.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            rd_data1_q   <= '0;
            rd_data2_q   <= '0;
            onehot_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_valid && wr_sel[i] && (i != ZERO_REG)) regs_q[i] <= wr_data;
            end
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            if (wr_illegal) onehot_err_q <= 1'b1;
        end
    end

    assign rd_data1   = rd_data1_q;
    assign rd_data2   = rd_data2_q;
    assign onehot_err = onehot_err_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Self-checking bench for regfile_onehot_wr: directed scenarios plus random traffic against an array model.
module tb_regfile_onehot_wr;

    localparam int W        = 64;
    localparam int NREG     = 32;
    localparam int AW       = $clog2(NREG);
    localparam int ZERO_REG = NREG - 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NREG-1:0] wr_sel;
    logic [W-1:0]    wr_data;
    logic [AW-1:0]   rd_addr1, rd_addr2;
    logic [W-1:0]    rd_data1, rd_data2;
    logic            onehot_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] model_regs [NREG];
    logic         model_err;
    logic [W-1:0] exp_rd1, exp_rd2;

    regfile_onehot_wr #(.W(W), .NREG(NREG), .ZERO_REG(ZERO_REG)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .onehot_err(onehot_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] model_read(input int addr, input int pc, input int k);
        if (addr == ZERO_REG) return '0;
`ifdef REGFILE_BYPASS_EN
        if (pc == 1 && k == addr) return wr_data;
`endif
        return model_regs[addr];
    endfunction

    // Predicts this edge's outputs from the current inputs, then advances the model past the edge.
    task automatic tick();
        int pc;
        int k;
        pc = $countones(wr_sel);
        k  = -1;
        for (int i = 0; i < NREG; i++) if (wr_sel[i]) k = i;
        if (!reset_n) begin
            exp_rd1   = '0;
            exp_rd2   = '0;
            model_err = 1'b0;
        end else begin
            exp_rd1 = model_read(int'(rd_addr1), pc, k);
            exp_rd2 = model_read(int'(rd_addr2), pc, k);
            if (pc > 1) model_err = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) model_regs[i] = '0;
        end else if (pc == 1 && k != ZERO_REG) begin
            model_regs[k] = wr_data;
        end
    endtask

    task automatic idle_inputs();
        wr_sel   = '0;
        wr_data  = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        wr_sel   = 32'h0000_0010;
        wr_data  = 64'h1234_5678_9ABC_DEF0;
        rd_addr1 = 5'd4;
        rd_addr2 = 5'd4;
        tick();
        tick();
        n_checks++;
        if (rd_data1 !== '0 || rd_data2 !== '0 || onehot_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd1=%h rd2=%h err=%b, required all zero", rd_data1, rd_data2, onehot_err);
        end
        reset_n = 1'b1;
        idle_inputs();
        for (int a = 0; a < NREG; a++) begin
            rd_addr1 = AW'(a);
            rd_addr2 = AW'(NREG - 1 - a);
            tick();
            n_checks++;
            if (rd_data1 !== '0 || rd_data2 !== '0) begin
                n_fail++;
                $display("FAIL reset_read addr %0d: rd1=%h rd2=%h, required 0", a, rd_data1, rd_data2);
            end
        end
    endtask

    task automatic test_basic_write();
        wr_sel  = 32'h0000_0008;
        wr_data = 64'hDEAD_BEEF;
        tick();
        wr_sel   = '0;
        rd_addr1 = 5'd3;
        rd_addr2 = 5'd4;
        tick();
        n_checks++;
        if (rd_data1 !== 64'hDEAD_BEEF || rd_data2 !== '0) begin
            n_fail++;
            $display("FAIL basic_write: rd1=%h rd2=%h, required rd1=deadbeef rd2=0", rd_data1, rd_data2);
        end
    endtask

    task automatic test_zero_reg();
        wr_sel  = 32'h8000_0000;
        wr_data = '1;
        rd_addr1 = 5'd31;
        tick();
        wr_sel   = '0;
        rd_addr2 = 5'd31;
        tick();
        n_checks++;
        if (rd_data1 !== '0 || rd_data2 !== '0 || onehot_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg: rd1=%h rd2=%h err=%b, required 0 0 0", rd_data1, rd_data2, onehot_err);
        end
    endtask

    task automatic test_illegal();
        wr_sel  = 32'h0000_0020;
        wr_data = 64'h55;
        tick();
        wr_sel  = 32'h0000_0060;
        wr_data = 64'hAA;
        tick();
        n_checks++;
        if (onehot_err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_flag: err=%b, required 1", onehot_err);
        end
        wr_sel   = '0;
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd6;
        tick();
        tick();
        n_checks++;
        if (rd_data1 !== 64'h55 || rd_data2 !== '0 || onehot_err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_nowrite: rd5=%h rd6=%h err=%b, required 55 0 1", rd_data1, rd_data2, onehot_err);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (onehot_err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_clear: err=%b after reset, required 0", onehot_err);
        end
    endtask

    task automatic test_same_cycle();
        logic [W-1:0] want;
        wr_sel  = 32'h0000_0080;
        wr_data = 64'h1;
        tick();
        wr_data  = 64'h2;
        rd_addr1 = 5'd7;
        rd_addr2 = 5'd7;
        tick();
`ifdef REGFILE_BYPASS_EN
        want = 64'h2;
`else
        want = 64'h1;
`endif
        n_checks++;
        if (rd_data1 !== want || rd_data2 !== want) begin
            n_fail++;
            $display("FAIL same_cycle: rd1=%h rd2=%h, required %h", rd_data1, rd_data2, want);
        end
        wr_sel = '0;
        tick();
        n_checks++;
        if (rd_data1 !== 64'h2 || rd_data2 !== 64'h2) begin
            n_fail++;
            $display("FAIL same_cycle_next: rd1=%h rd2=%h, required 2", rd_data1, rd_data2);
        end
    endtask

    task automatic test_reset_write();
        reset_n  = 1'b0;
        wr_sel   = 32'h0000_0200;
        wr_data  = 64'hF;
        rd_addr1 = 5'd9;
        tick();
        reset_n = 1'b1;
        wr_sel  = '0;
        tick();
        tick();
        n_checks++;
        if (rd_data1 !== '0) begin
            n_fail++;
            $display("FAIL reset_write: rd9=%h, required 0", rd_data1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            wr_sel = '0;
            if (r < 60)      wr_sel[$urandom_range(0, NREG - 1)] = 1'b1;
            else if (r < 63) wr_sel = NREG'($urandom);
            wr_data  = {$urandom, $urandom};
            rd_addr1 = AW'($urandom_range(0, NREG - 1));
            rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : AW'($urandom_range(0, NREG - 1));
            reset_n  = ($urandom_range(0, 199) != 0);
            tick();
            n_checks++;
            if (rd_data1 !== exp_rd1 || rd_data2 !== exp_rd2 || onehot_err !== model_err) begin
                n_fail++;
                $display("FAIL random[%0d]: rd1=%h rd2=%h err=%b, required %h %h %b",
                         n, rd_data1, rd_data2, onehot_err, exp_rd1, exp_rd2, model_err);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) model_regs[i] = '0;
        model_err = 1'b0;
        reset_n   = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_illegal();
        test_same_cycle();
        test_reset_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
